seq_alu: RTL and testbench



---
 rtl/seq_alu.sv | 188 ++++++++++++++++++
 tb/tb_seq_alu.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Registered ALU: single-cycle add/sub/compare and an iterative shift-add multiply
// producing a double-width product. Results and flags hold until the next completion.
module seq_alu #(
    parameter int WIDTH        = 8,
    parameter int OPCODE_WIDTH = 8
) (
    input  logic                    clock_in,
    input  logic                    reset_in,
    input  logic                    start_in,
    output logic                    ready_out,
    input  logic [OPCODE_WIDTH-1:0] opcode_in,
    input  logic [WIDTH-1:0]        alu_input1,
    input  logic [WIDTH-1:0]        alu_input2,
    output logic [WIDTH-1:0]        alu_output,
    output logic [WIDTH-1:0]        mult_high_out,
    output logic                    done_out,
    output logic                    illegal_op_out,
    output logic                    overflow_flag,
    output logic                    carry_flag,
    output logic                    zero_flag,
    output logic                    sign_flag,
    output logic                    parity_flag
);

    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = OPCODE_WIDTH'(1);
    localparam logic [OPCODE_WIDTH-1:0] OP_MUL  = OPCODE_WIDTH'(2);
    localparam logic [OPCODE_WIDTH-1:0] OP_EQ   = OPCODE_WIDTH'(3);
    localparam logic [OPCODE_WIDTH-1:0] OP_GT   = OPCODE_WIDTH'(4);
    localparam logic [OPCODE_WIDTH-1:0] OP_GTS  = OPCODE_WIDTH'(5);
    localparam logic [OPCODE_WIDTH-1:0] OP_ADDI = OPCODE_WIDTH'(9);
    localparam logic [OPCODE_WIDTH-1:0] OP_SUBI = OPCODE_WIDTH'(10);

    typedef enum logic {S_IDLE, S_MUL_RUN} state_t;

    function automatic logic add_ovf(input logic signed [WIDTH-1:0] a,
                                     input logic signed [WIDTH-1:0] b,
                                     input logic signed [WIDTH-1:0] r);
        return (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
    endfunction

    function automatic logic sub_ovf(input logic signed [WIDTH-1:0] a,
                                     input logic signed [WIDTH-1:0] b,
                                     input logic signed [WIDTH-1:0] r);
        return (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
    endfunction

    function automatic logic parity(input logic [WIDTH-1:0] v);
        return ^v;
    endfunction

    state_t                 state;
    logic [CNT_W-1:0]       count;
    logic [2*WIDTH-1:0]     mul_a_p0;
    logic [WIDTH-1:0]       mul_b_p0;
    logic [2*WIDTH-1:0]     acc_p0;
    logic [2*WIDTH-1:0]     partial;
    logic [2*WIDTH-1:0]     acc_next;

    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic [WIDTH:0]          sum_w;
    logic [WIDTH:0]          diff_w;
    logic [WIDTH-1:0]        alu_lo;
    logic                    alu_c, alu_v, alu_ill;

    logic                    accept, accept_mul, mul_last, wr_en;
    logic [WIDTH-1:0]        fin_lo, fin_hi;
    logic                    fin_c, fin_v, fin_z, fin_ill;

    assign a_s = alu_input1;
    assign b_s = alu_input2;

    assign accept     = start_in && ready_out;
    assign accept_mul = accept && (opcode_in == OP_MUL);
    assign mul_last   = (state == S_MUL_RUN) && (count == CNT_W'(WIDTH - 1));
    assign wr_en      = (accept && !accept_mul) || mul_last;

    always_comb begin
        sum_w   = {1'b0, alu_input1} + {1'b0, alu_input2};
        diff_w  = {1'b0, alu_input1} - {1'b0, alu_input2};
        alu_lo  = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_ill = 1'b0;
        case (opcode_in)
            OP_ADD, OP_ADDI: begin
                alu_lo = sum_w[WIDTH-1:0];
                alu_c  = sum_w[WIDTH];
                alu_v  = add_ovf(a_s, b_s, sum_w[WIDTH-1:0]);
            end
            OP_SUB, OP_SUBI: begin
                alu_lo = diff_w[WIDTH-1:0];
                alu_c  = diff_w[WIDTH];
                alu_v  = sub_ovf(a_s, b_s, diff_w[WIDTH-1:0]);
            end
            OP_EQ:   alu_lo = {{(WIDTH-1){1'b0}}, alu_input1 == alu_input2};
            OP_GT:   alu_lo = {{(WIDTH-1){1'b0}}, alu_input1 > alu_input2};
            OP_GTS:  alu_lo = {{(WIDTH-1){1'b0}}, a_s > b_s};
            OP_MUL:  alu_lo = '0;
            default: alu_ill = 1'b1;
        endcase
    end

    // One shift-add step per cycle; the last step's sum goes straight to the outputs.
    assign partial  = mul_b_p0[count] ? (mul_a_p0 << count) : '0;
    assign acc_next = acc_p0 + partial;

    always_comb begin
        if (state == S_MUL_RUN) begin
            fin_lo  = acc_next[WIDTH-1:0];
            fin_hi  = acc_next[2*WIDTH-1:WIDTH];
            fin_c   = |acc_next[2*WIDTH-1:WIDTH];
            fin_v   = |acc_next[2*WIDTH-1:WIDTH];
            fin_z   = (acc_next == '0);
            fin_ill = 1'b0;
        end else begin
            fin_lo  = alu_lo;
            fin_hi  = '0;
            fin_c   = alu_c;
            fin_v   = alu_v;
            fin_z   = (alu_lo == '0);
            fin_ill = alu_ill;
        end
    end

    // Stage p0: multiplier operands and accumulator (data only, no reset)
    always_ff @(posedge clock_in) begin
        if (accept_mul) begin
            mul_a_p0 <= {{WIDTH{1'b0}}, alu_input1};
            mul_b_p0 <= alu_input2;
            acc_p0   <= '0;
        end else if (state == S_MUL_RUN) begin
            acc_p0   <= acc_next;
        end
    end

    // Control and architectural result registers
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state          <= S_IDLE;
            ready_out      <= 1'b1;
            count          <= '0;
            done_out       <= 1'b0;
            alu_output     <= '0;
            mult_high_out  <= '0;
            illegal_op_out <= 1'b0;
            overflow_flag  <= 1'b0;
            carry_flag     <= 1'b0;
            zero_flag      <= 1'b1;
            sign_flag      <= 1'b0;
            parity_flag    <= 1'b0;
        end else begin
            done_out <= wr_en;
            if (wr_en) begin
                alu_output     <= fin_lo;
                mult_high_out  <= fin_hi;
                illegal_op_out <= fin_ill;
                overflow_flag  <= fin_v;
                carry_flag     <= fin_c;
                zero_flag      <= fin_z;
                sign_flag      <= fin_lo[WIDTH-1];
                parity_flag    <= parity(fin_lo);
            end
            case (state)
                S_IDLE: begin
                    if (accept_mul) begin
                        state     <= S_MUL_RUN;
                        ready_out <= 1'b0;
                        count     <= '0;
                    end
                end
                S_MUL_RUN: begin
                    if (mul_last) begin
                        state     <= S_IDLE;
                        ready_out <= 1'b1;
                        count     <= '0;
                    end else begin
                        count     <= count + CNT_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: stimulus pushes model results, a monitor pops on done_out.
`timescale 1ns/1ps
module tb_seq_alu;
    localparam int W   = 8;
    localparam int OPW = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           ready;
    logic [OPW-1:0] op;
    logic [W-1:0]   a, b;
    logic [W-1:0]   alu_out, hi_out;
    logic           done, ill, ovf, cry, zro, sgn, par;

    seq_alu #(.WIDTH(W), .OPCODE_WIDTH(OPW)) dut (
        .clock_in(clk), .reset_in(rst), .start_in(start), .ready_out(ready),
        .opcode_in(op), .alu_input1(a), .alu_input2(b),
        .alu_output(alu_out), .mult_high_out(hi_out), .done_out(done),
        .illegal_op_out(ill), .overflow_flag(ovf), .carry_flag(cry),
        .zero_flag(zro), .sign_flag(sgn), .parity_flag(par)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [W-1:0] lo, hi;
        logic         ill, v, c, z, s, p;
        int           at;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    function automatic bit is_legal(input logic [7:0] o);
        return (o <= 8'h05) || (o == 8'h09) || (o == 8'h0A);
    endfunction

    // Reference: plain integer arithmetic on the operand values.
    function automatic exp_t model(input logic [7:0] opc, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t   e;
        longint m  = longint'(1) << W;
        longint ux = longint'(x);
        longint uy = longint'(y);
        longint sx = (ux >= m / 2) ? ux - m : ux;
        longint sy = (uy >= m / 2) ? uy - m : uy;
        longint r;
        longint lo = 0;
        e.hi = '0; e.ill = 1'b0; e.v = 1'b0; e.c = 1'b0; e.at = 0;
        case (opc)
            8'h00, 8'h09: begin
                r = ux + uy; lo = r % m; e.c = (r >= m);
                r = sx + sy; e.v = (r >= m / 2) || (r < -(m / 2));
            end
            8'h01, 8'h0A: begin
                r = ux - uy; lo = (r + m) % m; e.c = (ux < uy);
                r = sx - sy; e.v = (r >= m / 2) || (r < -(m / 2));
            end
            8'h02: begin
                r = ux * uy; lo = r % m; e.hi = W'(r / m);
                e.c = (r / m) != 0; e.v = e.c;
            end
            8'h03: lo = (ux == uy) ? 1 : 0;
            8'h04: lo = (ux > uy) ? 1 : 0;
            8'h05: lo = (sx > sy) ? 1 : 0;
            default: begin lo = 0; e.ill = 1'b1; end
        endcase
        e.lo = W'(lo);
        e.z  = (opc == 8'h02) ? (ux * uy == 0) : (lo == 0);
        e.s  = (lo >= m / 2);
        e.p  = ($countones(e.lo) % 2) == 1;
        return e;
    endfunction

    // Monitor: every done_out pulse must match the oldest expectation, at its cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 64'(done), 64'(0));
                end else begin
                    e = sb.pop_front();
                    chk("done_cycle", 64'(cyc), 64'(e.at));
                    chk("alu_output", 64'(alu_out), 64'(e.lo));
                    chk("mult_high", 64'(hi_out), 64'(e.hi));
                    chk("illegal", 64'(ill), 64'(e.ill));
                    chk("overflow", 64'(ovf), 64'(e.v));
                    chk("carry", 64'(cry), 64'(e.c));
                    chk("zero", 64'(zro), 64'(e.z));
                    chk("sign", 64'(sgn), 64'(e.s));
                    chk("parity", 64'(par), 64'(e.p));
                end
            end
        end
    end

    // Called at a negedge; the following posedge is the accept edge.
    task automatic issue(input logic [7:0] opc, input logic [W-1:0] x, input logic [W-1:0] y,
                         input bit expect_res);
        exp_t e;
        chk("ready_before_issue", 64'(ready), 64'(1));
        e    = model(opc, x, y);
        e.at = cyc + 1 + ((opc == 8'h02) ? W : 0);
        if (expect_res) sb.push_back(e);
        start = 1'b1; op = opc; a = x; b = y;
        @(negedge clk);
        start = 1'b0; a = W'($urandom); b = W'($urandom);
    endtask

    task automatic mul_hold(input bit junk);
        for (int i = 0; i < W; i++) begin
            chk("ready_low_during_mul", 64'(ready), 64'(0));
            if (junk && i == 2) begin
                start = 1'b1; op = 8'h01; a = W'($urandom); b = W'($urandom);
            end
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_alu_output"}, 64'(alu_out), 64'(0));
        chk({tag, "_mult_high"}, 64'(hi_out), 64'(0));
        chk({tag, "_done"}, 64'(done), 64'(0));
        chk({tag, "_illegal"}, 64'(ill), 64'(0));
        chk({tag, "_ovf_cry"}, 64'({ovf, cry}), 64'(0));
        chk({tag, "_sgn_par"}, 64'({sgn, par}), 64'(0));
        chk({tag, "_zero"}, 64'(zro), 64'(1));
        chk({tag, "_ready"}, 64'(ready), 64'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]   opc;
        logic [W-1:0] x, y;
        int           waited;
        rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;
        @(negedge clk);

        issue(8'h00, 8'h7F, 8'h01, 1);
        chk("add_7f_01_result", 64'(alu_out), 64'(8'h80));
        chk("add_7f_01_flags_vcszp", 64'({ovf, cry, sgn, zro, par}), 64'(5'b10101));
        chk("add_done", 64'(done), 64'(1));
        @(negedge clk);
        chk("add_done_single", 64'(done), 64'(0));

        issue(8'h01, 8'h00, 8'h01, 1);
        chk("sub_00_01_result", 64'(alu_out), 64'(8'hFF));
        chk("sub_00_01_flags_vcszp", 64'({ovf, cry, sgn, zro, par}), 64'(5'b01100));
        issue(8'h09, 8'h05, 8'h03, 1);
        chk("addi_result", 64'(alu_out), 64'(8'h08));
        chk("addi_done_second", 64'(done), 64'(1));

        issue(8'h02, 8'h10, 8'h10, 1);
        mul_hold(1);
        chk("mul_lo", 64'(alu_out), 64'(8'h00));
        chk("mul_hi", 64'(hi_out), 64'(8'h01));
        chk("mul_done_ready", 64'({done, ready}), 64'(2'b11));
        @(negedge clk);
        chk("mul_junk_ignored", 64'(done), 64'(0));

        issue(8'h04, 8'h80, 8'h01, 1);
        chk("gt_result", 64'(alu_out), 64'(1));
        issue(8'h05, 8'h80, 8'h01, 1);
        chk("gts_result_zero", 64'({alu_out, zro}), 64'({8'h00, 1'b1}));
        issue(8'h03, 8'h5A, 8'h5A, 1);
        chk("eq_result", 64'(alu_out), 64'(1));

        issue(8'h02, 8'hFF, 8'hFF, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset("mul_abort");
        repeat (W + 2) @(negedge clk);

        issue(8'h07, 8'h12, 8'h34, 1);
        chk("illegal_flag", 64'({ill, zro, alu_out}), 64'({1'b1, 1'b1, 8'h00}));
        issue(8'h00, 8'h01, 8'h02, 1);
        chk("illegal_cleared", 64'(ill), 64'(0));

        for (int k = 0; k < 80; k++) begin
            case ($urandom_range(0, 9))
                0: opc = 8'h00;  1: opc = 8'h01;  2: opc = 8'h02;
                3: opc = 8'h03;  4: opc = 8'h04;  5: opc = 8'h05;
                6: opc = 8'h09;  7: opc = 8'h0A;
                default: begin
                    do opc = 8'($urandom); while (is_legal(opc));
                end
            endcase
            x = W'($urandom);
            y = W'($urandom);
            if (k % 7 == 0) x = (k % 2 == 0) ? 8'h00 : 8'hFF;
            issue(opc, x, y, 1);
            if (opc == 8'h02) mul_hold(1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        waited = 0;
        while (sb.size() != 0 && waited < 4 * W) begin
            @(negedge clk);
            waited++;
        end
        chk("scoreboard_drained", 64'(sb.size()), 64'(0));
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
